button_scheduler: RTL and testbench
===================================

BUTTON_SCHEDULER -- requirements
Module: button_scheduler

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of raw push-buttons served.
REQ-002 SHALL have parameter DEB_MAX, default 1000000, consecutive high cycles required to accept a press.
REQ-003 SHALL have parameter LONG_MAX, default 50000000, held cycles after acceptance that make a press "long".
REQ-004 SHALL have parameter REP_MAX, default 10000000, auto-repeat period in cycles (used only under BTN_AUTOREPEAT_EN).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port btn_i  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port evt_valid  output  1  event available.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-010 SHALL have port evt_id  output  $clog2(N_BTN)  index of the button producing the event.
REQ-011 SHALL have port evt_long  output  1  1 = long/repeat event, 0 = short event.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass btn_i through a 2-flop synchronizer per bit; all logic below uses synchronized levels.
REQ-014 SHALL use a single shared debounce/hold counter, width $clog2(max(DEB_MAX,LONG_MAX,REP_MAX)+1), serving one button at a time.
REQ-015 SHALL implement states IDLE, DEBOUNCE, HELD, EMIT, WAIT_REL.
REQ-016 IDLE: if any synchronized button is high, SHALL select one round-robin starting at pointer rr_ptr, clear the counter, go to DEBOUNCE.
REQ-017 DEBOUNCE: the selected button low SHALL return to IDLE with no event and rr_ptr = selected+1 (mod N_BTN); a counter reaching DEB_MAX-1 with the button still high SHALL go to HELD with the counter cleared.
REQ-018 HELD: release before the counter reaches LONG_MAX-1 SHALL load a short event (evt_long=0) and go to EMIT; reaching LONG_MAX-1 while held SHALL load a long event (evt_long=1) and go to EMIT.
REQ-019 EMIT: evt_valid SHALL be 1, with evt_id/evt_long stable, until the cycle evt_ready=1; then go to WAIT_REL if the button is still high, else IDLE.
REQ-020 WAIT_REL: SHALL wait for release, then go to IDLE with rr_ptr = selected+1.
REQ-021 Buttons other than the selected one SHALL be ignored outside IDLE; no event is queued for them.
REQ-022 evt_ready while evt_valid=0 SHALL have no effect; at most one event SHALL be accepted per button press (excluding repeats).
REQ-023 Simultaneous presses SHALL be served in round-robin order from rr_ptr, one press per IDLE visit.

Reset
REQ-024 reset SHALL force IDLE, rr_ptr=0, counter=0, synchronizer flops=0, evt_valid=0, evt_id=0, evt_long=0, busy=0 on the next edge.
REQ-025 reset asserted mid-press or during EMIT SHALL discard the pending event; a button still held after reset deasserts SHALL be treated as a new press.

Configuration
REQ-026 With BTN_AUTOREPEAT_EN defined, WAIT_REL after a long event SHALL count REP_MAX cycles while held and, on reaching REP_MAX-1, load a repeat event (evt_long=1) and go to EMIT.
REQ-027 Without BTN_AUTOREPEAT_EN, WAIT_REL SHALL only wait for release and the repeat counter path SHALL not exist.

Structure
REQ-028 SHALL place the state enum, N_BTN default and its id-width constant in shared package btn_pkg.
REQ-029 SHALL instantiate sub-module btn_sync (N_BTN-wide 2-flop synchronizer bank).

Verification (DEB_MAX=4, LONG_MAX=16, REP_MAX=8, N_BTN=4, evt_ready=1 unless stated)
REQ-030 btn_i[2] high 10 cycles then low -> one event evt_id=2, evt_long=0, evt_valid for exactly 1 cycle.
REQ-031 btn_i[1] high 3 cycles (bounce) then low -> no event, busy returns to 0.
REQ-032 btn_i[0] held 40 cycles -> one event evt_id=0, evt_long=1; with BTN_AUTOREPEAT_EN, additional long events every 8 cycles until release.
REQ-033 btn_i[0] and btn_i[3] held together, each released and re-pressed -> events ordered id 0, 3, 0, 3.
REQ-034 evt_ready=0 for 5 cycles during EMIT -> evt_valid, evt_id, evt_long held stable, single event accepted when evt_ready=1.
REQ-035 reset pulsed during EMIT -> evt_valid=0 next cycle, no event is ever accepted for that press.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the button scheduler: FSM state encoding and sizing helpers.
package btn_pkg;

  localparam int unsigned N_BTN_DEF = 4;
  localparam int unsigned ID_W_DEF  = (N_BTN_DEF > 1) ? $clog2(N_BTN_DEF) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HELD     = 3'd2,
    ST_EMIT     = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// N-wide two-flop synchronizer bank for asynchronous button levels.
module btn_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_scheduler.sv
// Debounces N_BTN buttons with one shared counter and reports short/long presses round-robin.
// Optional auto-repeat of long presses is enabled by defining BTN_AUTOREPEAT_EN.
module button_scheduler
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN    = N_BTN_DEF,
  parameter int unsigned DEB_MAX  = 1000000,
  parameter int unsigned LONG_MAX = 50000000,
  parameter int unsigned REP_MAX  = 10000000,
  localparam int unsigned ID_W    = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_i,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(max3(DEB_MAX, LONG_MAX, REP_MAX) + 1);

  logic [N_BTN-1:0] btn_s;
  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  sel;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  pick_c;
  logic [ID_W-1:0]  next_ptr_c;
  logic             sel_lvl_c;

  btn_sync #(.W(N_BTN)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_i),
    .q    (btn_s)
  );

  // First pressed button at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned k;
    logic        hit;
    pick_c = rr_ptr;
    hit    = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= N_BTN) k = k - N_BTN;
      if (!hit && btn_s[ID_W'(k)]) begin
        pick_c = ID_W'(k);
        hit    = 1'b1;
      end
    end
  end

  assign next_ptr_c = (sel == ID_W'(N_BTN - 1)) ? '0 : sel + ID_W'(1);
  assign sel_lvl_c  = btn_s[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      cnt       <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|btn_s) begin
            sel   <= pick_c;
            cnt   <= '0;
            state <= ST_DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!sel_lvl_c) begin
            rr_ptr <= next_ptr_c;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end else if (cnt == CNT_W'(DEB_MAX - 1)) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!sel_lvl_c || cnt == CNT_W'(LONG_MAX - 1)) begin
            evt_valid <= 1'b1;
            evt_id    <= sel;
            evt_long  <= sel_lvl_c;
            state     <= ST_EMIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            cnt       <= '0;
            if (sel_lvl_c) begin
              state <= ST_WAIT_REL;
            end else begin
              rr_ptr <= next_ptr_c;
              state  <= ST_IDLE;
              busy   <= 1'b0;
            end
          end
        end
        ST_WAIT_REL: begin
          if (!sel_lvl_c) begin
            rr_ptr <= next_ptr_c;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          // evt_long still flags that the last event of this press was long.
          else if (evt_long) begin
            if (cnt == CNT_W'(REP_MAX - 1)) begin
              evt_valid <= 1'b1;
              state     <= ST_EMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_scheduler.sv
// Scoreboard bench for button_scheduler with small debounce/long/repeat constants.
module tb_button_scheduler;

  localparam int unsigned N_BTN = 4;

  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } evt_t;

  logic             clk;
  logic             reset;
  logic [N_BTN-1:0] btn_i;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_id;
  logic             evt_long;
  logic             busy;

  evt_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  button_scheduler #(
    .N_BTN   (N_BTN),
    .DEB_MAX (4),
    .LONG_MAX(16),
    .REP_MAX (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn_i),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_long (evt_long),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got id=%0d long=%0d, expected none", evt_id, evt_long);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        if ({evt_id, evt_long} !== {e.id, e.lng}) begin
          bad++;
          $display("FAIL event: got id=%0d long=%0d, expected id=%0d long=%0d",
                   evt_id, evt_long, e.id, e.lng);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; btn_i = '0; evt_ready = 1'b1;
    cycles(3);
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    total++;
    if (evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
    total++;
    if (evt_long !== 1'b0) begin bad++; $display("FAIL reset_long: got %b expected 0", evt_long); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_short;
    int hi;
    hi = 0;
    exp_q.push_back('{id: 2'd2, lng: 1'b0});
    btn_i[2] = 1'b1;
    cycles(10);
    btn_i[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (evt_valid) hi++;
      cycles(1);
    end
    total++;
    if (hi !== 1) begin bad++; $display("FAIL short_valid_width: got %0d cycles expected 1", hi); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL short_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_bounce;
    btn_i[1] = 1'b1;
    cycles(3);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bounce_busy_hi: got %b expected 1", busy); end
    btn_i[1] = 1'b0;
    cycles(20);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bounce_busy_lo: got %b expected 0", busy); end
  endtask

  task automatic test_long;
    exp_q.push_back('{id: 2'd0, lng: 1'b1});
`ifdef BTN_AUTOREPEAT_EN
    exp_q.push_back('{id: 2'd0, lng: 1'b1});
    exp_q.push_back('{id: 2'd0, lng: 1'b1});
`endif
    btn_i[0] = 1'b1;
    cycles(44);
    btn_i[0] = 1'b0;
    cycles(30);
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL long_missing: got %0d pending expected 0", exp_q.size()); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL long_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back('{id: 2'd0, lng: 1'b0});
      exp_q.push_back('{id: 2'd3, lng: 1'b0});
      btn_i = 4'b1001;
      cycles(10);
      btn_i[0] = 1'b0;
      cycles(12);
      btn_i[3] = 1'b0;
      cycles(10);
    end
    cycles(10);
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL rr_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    int n;
    evt_ready = 1'b0;
    exp_q.push_back('{id: 2'd1, lng: 1'b0});
    btn_i[1] = 1'b1;
    cycles(10);
    btn_i[1] = 1'b0;
    n = 0;
    while (!evt_valid && n < 50) begin cycles(1); n++; end
    total++;
    if (evt_valid !== 1'b1) begin bad++; $display("FAIL stall_timeout: got valid=%b expected 1", evt_valid); end
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      total++;
      if ({evt_valid, evt_id, evt_long} !== {1'b1, 2'd1, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold: got valid=%b id=%0d long=%b expected 1/1/0", evt_valid, evt_id, evt_long);
      end
    end
    evt_ready = 1'b1;
    cycles(20);
    total++;
    if (exp_q.size() !== 0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: got pending=%0d valid=%b expected 0/0", exp_q.size(), evt_valid);
    end
  endtask

  task automatic test_reset_emit;
    int n;
    evt_ready = 1'b0;
    btn_i[2] = 1'b1;
    cycles(10);
    btn_i[2] = 1'b0;
    n = 0;
    while (!evt_valid && n < 50) begin cycles(1); n++; end
    total++;
    if (evt_valid !== 1'b1) begin bad++; $display("FAIL rst_emit_timeout: got valid=%b expected 1", evt_valid); end
    reset = 1'b1;
    cycles(1);
    total++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_emit_clear: got valid=%b busy=%b expected 0/0", evt_valid, busy);
    end
    reset = 1'b0;
    evt_ready = 1'b1;
    cycles(30);
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_emit_stale: got valid=%b expected 0", evt_valid); end
  endtask

  initial begin
    reset = 1'b1; btn_i = '0; evt_ready = 1'b1;
    test_reset;
    test_short;
    test_bounce;
    test_long;
    test_round_robin;
    test_stall;
    test_reset_emit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
